// File: rtl/ahb_sram_subordinate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ahb_sram_subordinate                                            |
// | Brief    : Memory-backed AHB subordinate with programmable wait states and |
// |            two-cycle ERROR response for illegal transfers.                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ahb_sram_subordinate #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic                    hsel,
    input  logic [ADDR_WIDTH-1:0]   haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    input  logic [DATA_WIDTH/8-1:0] hwstrb,
    input  logic                    hready,
    output logic                    hreadyout,
    output logic                    hresp,
    output logic [DATA_WIDTH-1:0]   hrdata
);

    localparam int unsigned C_BYTES     = DATA_WIDTH / 8;
    localparam int unsigned C_BYTE_BITS = $clog2(C_BYTES);
    localparam int unsigned C_IDX_BITS  = $clog2(MEM_DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [3:0]            r_count;
    logic [3:0]            w_next_count;
    logic                  r_write;
    logic [C_IDX_BITS-1:0] r_idx;
    logic [C_BYTES-1:0]    r_lanes;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_take;
    logic                  w_legal;
    logic                  w_size_ok;
    logic                  w_aligned;
    logic                  w_in_range;
    logic [7:0]            w_low;
    logic [7:0]            w_align_mask;
    logic [7:0]            w_off;
    logic [8:0]            w_end;
    logic [C_BYTES-1:0]    w_lane_mask;
    logic [C_IDX_BITS-1:0] w_idx;
    logic                  w_unused;

    assign w_unused = htrans[0];

    // A new address phase can only land while the bus is ready from our side.
    assign w_take = hsel & hready & htrans[1] &
                    ((r_state == S_IDLE) | (r_state == S_DATA) | (r_state == S_ERR2));

    assign w_low        = 8'(haddr);
    assign w_align_mask = (8'd1 << hsize) - 8'd1;
    assign w_size_ok    = (32'(hsize) <= 32'(C_BYTE_BITS));
    assign w_aligned    = ((w_low & w_align_mask) == 8'd0);
    assign w_in_range   = ((haddr >> (C_BYTE_BITS + C_IDX_BITS)) == '0);
    assign w_legal      = w_size_ok & w_aligned & w_in_range;
    assign w_idx        = haddr[C_BYTE_BITS +: C_IDX_BITS];
    assign w_off        = w_low & 8'(C_BYTES - 1);
    assign w_end        = {1'b0, w_off} + (9'd1 << hsize);

    always_comb begin
        w_lane_mask = '0;
        for (int i = 0; i < int'(C_BYTES); i++) begin
            w_lane_mask[i] = (9'(i) >= {1'b0, w_off}) && (9'(i) < w_end);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (!w_take) begin
                    w_next_state = S_IDLE;
                end else if (!w_legal) begin
                    w_next_state = S_ERR1;
                end else if (WAIT_STATES > 0) begin
                    w_next_state = S_WAIT;
                    w_next_count = 4'(WAIT_STATES - 1);
                end else begin
                    w_next_state = S_DATA;
                end
            end
            S_WAIT: begin
                if (r_count == 4'd0) begin
                    w_next_state = S_DATA;
                end else begin
                    w_next_count = r_count - 4'd1;
                end
            end
            S_ERR1:  w_next_state = S_ERR2;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_lanes <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            if (w_take) begin
                r_write <= hwrite;
                r_idx   <= w_idx;
                r_lanes <= w_lane_mask;
            end
        end
    end

    // Array contents survive reset; only the commit of an in-flight write is suppressed.
    generate
        for (genvar g = 0; g < int'(C_BYTES); g++) begin : g_lane
            always_ff @(posedge hclk) begin
                if (!hreset && (r_state == S_DATA) && r_write && hwstrb[g] && r_lanes[g]) begin
                    r_mem[r_idx][g*8 +: 8] <= hwdata[g*8 +: 8];
                end
            end
        end
    endgenerate

    assign hreadyout = !((r_state == S_WAIT) || (r_state == S_ERR1));
    assign hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);
    assign hrdata    = (r_state == S_DATA) ? r_mem[r_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_subordinate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ahb_sram_subordinate                                         |
// | Brief    : Two subordinates (0 and 3 wait states) against a transfer model.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ahb_sram_subordinate;

    localparam int DEPTH = 1024;
    localparam int WORDS = 32;

    logic        clk = 1'b0;
    logic        hreset [2];
    logic        hsel [2];
    logic        hwrite [2];
    logic        hready [2];
    logic        hreadyout [2];
    logic        hresp [2];
    logic        hold [2];
    logic [31:0] haddr [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];
    logic [1:0]  htrans [2];
    logic [2:0]  hsize [2];
    logic [3:0]  hwstrb [2];

    int          ws [2];
    int          ph_kind [2];
    int          ph_left [2];
    logic        ph_write [2];
    int          ph_word [2];
    logic [3:0]  ph_lanes [2];
    logic [31:0] mdl_mem [2][WORDS];
    logic        exp_rdy [2];
    logic        exp_resp [2];
    logic [31:0] exp_data [2];
    logic        obs_rdy [2];
    logic        obs_resp [2];
    logic [31:0] obs_data [2];

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    ahb_sram_subordinate #(.WAIT_STATES(0)) u_dut0 (
        .hclk(clk), .hreset(hreset[0]), .hsel(hsel[0]), .haddr(haddr[0]),
        .htrans(htrans[0]), .hwrite(hwrite[0]), .hsize(hsize[0]), .hwdata(hwdata[0]),
        .hwstrb(hwstrb[0]), .hready(hready[0]), .hreadyout(hreadyout[0]),
        .hresp(hresp[0]), .hrdata(hrdata[0])
    );

    ahb_sram_subordinate #(.WAIT_STATES(3)) u_dut3 (
        .hclk(clk), .hreset(hreset[1]), .hsel(hsel[1]), .haddr(haddr[1]),
        .htrans(htrans[1]), .hwrite(hwrite[1]), .hsize(hsize[1]), .hwdata(hwdata[1]),
        .hwstrb(hwstrb[1]), .hready(hready[1]), .hreadyout(hreadyout[1]),
        .hresp(hresp[1]), .hrdata(hrdata[1])
    );

    // Phase kinds: 0 none, 1 OKAY (ph_left wait cycles before the data cycle), 2 ERROR.
    task automatic model_expect(input int d);
        exp_rdy[d]  = 1'b1;
        exp_resp[d] = 1'b0;
        exp_data[d] = 32'h0;
        if (ph_kind[d] == 1) begin
            if (ph_left[d] > 0) exp_rdy[d] = 1'b0;
            else exp_data[d] = mdl_mem[d][ph_word[d]];
        end else if (ph_kind[d] == 2) begin
            exp_resp[d] = 1'b1;
            exp_rdy[d]  = (ph_left[d] == 1);
        end
    endtask

    task automatic model_edge(input int d);
        int unsigned a;
        int unsigned nb;
        bit          finishing;
        a  = haddr[d];
        nb = 1 << hsize[d];
        if (hreset[d]) begin
            ph_kind[d] = 0;
        end else begin
            finishing = (ph_kind[d] == 1 && ph_left[d] == 0) || (ph_kind[d] == 2 && ph_left[d] == 1);
            if (ph_kind[d] == 1 && ph_left[d] == 0 && ph_write[d]) begin
                for (int i = 0; i < 4; i++)
                    if (hwstrb[d][i] && ph_lanes[d][i])
                        mdl_mem[d][ph_word[d]][i*8 +: 8] = hwdata[d][i*8 +: 8];
            end
            if (hready[d] && hsel[d] && htrans[d][1]) begin
                if (nb <= 4 && (a % nb) == 0 && a < DEPTH * 4) begin
                    ph_kind[d]  = 1;
                    ph_left[d]  = ws[d];
                    ph_write[d] = hwrite[d];
                    ph_word[d]  = int'(a / 4);
                    for (int i = 0; i < 4; i++)
                        ph_lanes[d][i] = (i >= int'(a % 4)) && (i < int'(a % 4 + nb));
                end else begin
                    ph_kind[d] = 2;
                    ph_left[d] = 2;
                end
            end else if (finishing || ph_kind[d] == 0) begin
                ph_kind[d] = 0;
            end else begin
                ph_left[d] = ph_left[d] - 1;
            end
        end
    endtask

    task automatic tick(input bit chk);
        for (int d = 0; d < 2; d++) begin
            model_expect(d);
            hready[d] = exp_rdy[d] & ~hold[d];
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            obs_rdy[d]  = hreadyout[d];
            obs_resp[d] = hresp[d];
            obs_data[d] = hrdata[d];
            if (chk) begin
                n_vec++;
                if (obs_rdy[d] !== exp_rdy[d] || obs_resp[d] !== exp_resp[d] || obs_data[d] !== exp_data[d]) begin
                    n_mis++;
                    $display("FAIL cycle dut%0d t=%0t: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                             d, $time, obs_rdy[d], obs_resp[d], obs_data[d], exp_rdy[d], exp_resp[d], exp_data[d]);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) model_edge(d);
    endtask

    task automatic chk_lit(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic set_idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'd0;
        hwrite[d] = 1'($urandom);
        haddr[d]  = $urandom;
        hsize[d]  = 3'($urandom);
        hold[d]   = 1'b0;
    endtask

    task automatic set_ap(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] sz);
        hsel[d]   = 1'b1;
        htrans[d] = 2'd2;
        hwrite[d] = wr;
        haddr[d]  = addr;
        hsize[d]  = sz;
        hold[d]   = 1'b0;
    endtask

    // Single non-pipelined transfer; reports first and last data-phase observations.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [3:0] st, output int ncyc,
                        output logic f_rdy, output logic f_resp, output logic l_resp,
                        output logic [31:0] l_data);
        set_idle(1 - d);
        set_ap(d, wr, addr, sz);
        tick(1'b1);
        set_idle(d);
        hwdata[d] = wd;
        hwstrb[d] = st;
        ncyc   = 0;
        f_rdy  = 1'b0;
        f_resp = 1'b0;
        do begin
            tick(1'b1);
            ncyc++;
            if (ncyc == 1) begin
                f_rdy  = obs_rdy[d];
                f_resp = obs_resp[d];
            end
        end while (!exp_rdy[d] && ncyc < 20);
        if (!exp_rdy[d]) begin
            n_vec++;
            n_mis++;
            $display("FAIL xfer_timeout dut%0d: got no ready within %0d cycles, want completion", d, ncyc);
        end
        l_resp = obs_resp[d];
        l_data = obs_data[d];
    endtask

    task automatic rand_ap(input int d);
        int unsigned r;
        int unsigned w;
        r = $urandom_range(0, 9);
        w = $urandom_range(0, WORDS - 1);
        hsel[d]   = ($urandom_range(0, 9) != 0);
        htrans[d] = 2'($urandom);
        hwrite[d] = 1'($urandom);
        hold[d]   = ($urandom_range(0, 7) == 0);
        hsize[d]  = 3'($urandom_range(0, 2));
        if (r < 7) begin
            haddr[d] = w * 4 + ((($urandom_range(0, 3)) >> hsize[d]) << hsize[d]);
        end else if (r == 7) begin
            hsize[d] = 3'($urandom_range(1, 2));
            haddr[d] = w * 4 + 1;
        end else if (r == 8) begin
            hsize[d] = 3'd2;
            haddr[d] = DEPTH * 4 + $urandom_range(0, 255) * 4;
        end else begin
            hsize[d] = 3'($urandom_range(3, 7));
            haddr[d] = w * 4;
        end
        hwdata[d] = $urandom;
        hwstrb[d] = 4'($urandom);
    endtask

    initial begin
        int          nc;
        logic        fr;
        logic        fp;
        logic        lp;
        logic [31:0] ld;
        logic        seq_rdy [4];

        ws[0] = 0;
        ws[1] = 3;
        for (int d = 0; d < 2; d++) begin
            ph_kind[d] = 0;
            ph_left[d] = 0;
            hreset[d]  = 1'b1;
            hwdata[d]  = 32'h0;
            hwstrb[d]  = 4'h0;
            set_idle(d);
        end
        tick(1'b0);
        tick(1'b0);
        hreset[0] = 1'b0;
        hreset[1] = 1'b0;
        tick(1'b1);
        for (int d = 0; d < 2; d++) begin
            chk_lit($sformatf("reset_ready%0d", d), 32'(obs_rdy[d]), 32'd1);
            chk_lit($sformatf("reset_resp%0d", d), 32'(obs_resp[d]), 32'd0);
            chk_lit($sformatf("reset_rdata%0d", d), obs_data[d], 32'd0);
        end

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < WORDS; w++)
                xfer(d, 1'b1, 32'(w * 4), 3'd2, $urandom, 4'hF, nc, fr, fp, lp, ld);

        // Write then read pipelined back to back with no wait states.
        set_ap(0, 1'b1, 32'h10, 3'd2);
        tick(1'b1);
        set_ap(0, 1'b0, 32'h10, 3'd2);
        hwdata[0] = 32'hDEADBEEF;
        hwstrb[0] = 4'hF;
        tick(1'b1);
        chk_lit("t1_write_ready", 32'(obs_rdy[0]), 32'd1);
        set_idle(0);
        tick(1'b1);
        chk_lit("t1_read_data", obs_data[0], 32'hDEADBEEF);
        chk_lit("t1_read_resp", 32'(obs_resp[0]), 32'd0);

        // Wait-state timing and pipelined accept only on the ready cycle.
        xfer(1, 1'b1, 32'h0, 3'd2, 32'hCAFEF00D, 4'hF, nc, fr, fp, lp, ld);
        chk_lit("t2_write_cycles", 32'(nc), 32'd4);
        set_ap(1, 1'b0, 32'h0, 3'd2);
        tick(1'b1);
        set_ap(1, 1'b0, 32'h4, 3'd2);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1);
            seq_rdy[i] = obs_rdy[1];
            if (i == 3) chk_lit("t2_read_data", obs_data[1], 32'hCAFEF00D);
        end
        chk_lit("t2_ready_seq", {28'd0, seq_rdy[0], seq_rdy[1], seq_rdy[2], seq_rdy[3]}, 32'b0001);
        set_idle(1);
        tick(1'b1);
        chk_lit("t2_next_accepted", 32'(obs_rdy[1]), 32'd0);
        repeat (4) tick(1'b1);

        // Byte write into the top lane.
        xfer(0, 1'b1, 32'h10, 3'd2, 32'h11223344, 4'hF, nc, fr, fp, lp, ld);
        xfer(0, 1'b1, 32'h13, 3'd0, 32'hAA000000, 4'hF, nc, fr, fp, lp, ld);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, 4'h0, nc, fr, fp, lp, ld);
        chk_lit("t3_byte_merge", ld, 32'hAA223344);

        // Illegal transfers: misaligned and out of range, both aliasing word 0.
        xfer(0, 1'b1, 32'h0, 3'd2, 32'h01020304, 4'hF, nc, fr, fp, lp, ld);
        xfer(0, 1'b1, 32'h2, 3'd2, 32'hFFFFFFFF, 4'hF, nc, fr, fp, lp, ld);
        chk_lit("t4_misalign_cycles", 32'(nc), 32'd2);
        chk_lit("t4_misalign_first", {30'd0, fr, fp}, 32'b01);
        chk_lit("t4_misalign_last_resp", 32'(lp), 32'd1);
        xfer(0, 1'b1, 32'(DEPTH * 4), 3'd2, 32'hFFFFFFFF, 4'hF, nc, fr, fp, lp, ld);
        chk_lit("t4_range_first", {30'd0, fr, fp}, 32'b01);
        xfer(0, 1'b0, 32'h0, 3'd2, 32'h0, 4'h0, nc, fr, fp, lp, ld);
        chk_lit("t4_array_unchanged", ld, 32'h01020304);

        set_ap(0, 1'b1, 32'h20, 3'd2);
        tick(1'b1);
        set_ap(0, 1'b0, 32'h20, 3'd2);
        hwdata[0] = 32'h5A5A5A5A;
        hwstrb[0] = 4'hF;
        tick(1'b1);
        set_idle(0);
        tick(1'b1);
        chk_lit("t5_bypass", obs_data[0], 32'h5A5A5A5A);

        // Reset in the middle of a waited write aborts it.
        xfer(1, 1'b1, 32'h20, 3'd2, 32'h0BADF00D, 4'hF, nc, fr, fp, lp, ld);
        set_ap(1, 1'b1, 32'h20, 3'd2);
        tick(1'b1);
        set_idle(1);
        hwdata[1] = 32'hFFFFFFFF;
        hwstrb[1] = 4'hF;
        tick(1'b1);
        hreset[1] = 1'b1;
        tick(1'b1);
        hreset[1] = 1'b0;
        tick(1'b1);
        chk_lit("t6_after_reset", {30'd0, obs_rdy[1], obs_resp[1]}, 32'b10);
        xfer(1, 1'b0, 32'h20, 3'd2, 32'h0, 4'h0, nc, fr, fp, lp, ld);
        chk_lit("t6_old_data", ld, 32'h0BADF00D);

        for (int c = 0; c < 1500; c++) begin
            rand_ap(0);
            rand_ap(1);
            tick(1'b1);
        end
        set_idle(0);
        set_idle(1);
        repeat (8) tick(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
